// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, word-addressed memory between the instruction-fetch
// requester and the load/store requester. Data accesses win ties, but a streak
// limit guarantees that a waiting fetch is served after MAX_D_STREAK data grants.
// A per-transaction timeout aborts a hung memory access and raises a sticky flag.
// Every output is a register, so there is no combinational path from any input.

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err,
    output logic              bus_err
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TMO_W    = $clog2(TIMEOUT);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST     = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 owner_d, owner_d_nxt;
    logic [STREAK_W-1:0]  streak, streak_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;

    logic                 grant_d, grant_f;

    logic                 mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]    mem_addr_nxt;
    logic [DATA_W-1:0]    mem_wdata_nxt;
    logic                 if_done_nxt, d_done_nxt;
    logic [DATA_W-1:0]    if_rdata_nxt, d_rdata_nxt;
    logic                 err_nxt, bus_err_nxt;

    // Next-state and next-output logic: arbitration in IDLE, completion or abort in ISSUE.
    always_comb begin
        state_nxt     = state;
        owner_d_nxt   = owner_d;
        streak_nxt    = streak;
        tmo_cnt_nxt   = tmo_cnt;
        grant_d       = 1'b0;
        grant_f       = 1'b0;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_done_nxt   = 1'b0;
        d_done_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        err_nxt       = 1'b0;
        bus_err_nxt   = bus_err;

        case (state)
            IDLE: begin
                if (d_req && (!if_req || (streak != STREAK_LIMIT))) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_f = 1'b1;
                end

                if (grant_f || !if_req) begin
                    streak_nxt = '0;
                end else if (grant_d && (streak != STREAK_LIMIT)) begin
                    streak_nxt = streak + 1'b1;
                end

                if (grant_d) begin
                    owner_d_nxt   = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    tmo_cnt_nxt   = '0;
                    state_nxt     = ISSUE;
                end else if (grant_f) begin
                    owner_d_nxt   = 1'b0;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    tmo_cnt_nxt   = '0;
                    state_nxt     = ISSUE;
                end
            end

            ISSUE: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = RESP;
                    if (owner_d) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = mem_we ? '0 : mem_rdata;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    bus_err_nxt = 1'b1;
                    state_nxt   = RESP;
                    if (owner_d) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = '0;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = '0;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction without a done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= '0;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner_d   <= owner_d_nxt;
            streak    <= streak_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_done   <= if_done_nxt;
            d_done    <= d_done_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            err       <= err_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives the fetch and load/store ports, models a variable-latency memory, and
// checks every completion against a queue of expected results.

module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;
    logic        bus_err;

    logic        resp_ack;
    logic        force_ack;
    int          ack_delay;
    int          wait_cnt;
    logic [31:0] store_model [logic [31:0]];

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    assign mem_ack = resp_ack | force_ack;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_STREAK(4),
        .TIMEOUT     (8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err),
        .bus_err  (bus_err)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Initial memory contents for any address never stored to.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h8C22_0004;
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    // Memory model: acks after ack_delay cycles of mem_req (negative = never).
    always @(negedge clock) begin
        if (!reset_n || !mem_req) begin
            resp_ack  = 1'b0;
            wait_cnt  = 0;
            mem_rdata = 32'h1234_5678;
        end else if (ack_delay >= 0 && wait_cnt == ack_delay) begin
            resp_ack = 1'b1;
            wait_cnt = wait_cnt + 1;
            if (mem_we) begin
                store_model[mem_addr] = mem_wdata;
                mem_rdata = 32'h5A5A_5A5A;
            end else begin
                mem_rdata = store_model.exists(mem_addr) ? store_model[mem_addr] : init_word(mem_addr);
            end
        end else begin
            resp_ack  = 1'b0;
            wait_cnt  = wait_cnt + 1;
            mem_rdata = 32'h1234_5678;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, err, bus_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs mem_req=%b mem_addr=%h if_done=%b d_done=%b bus_err=%b, expected all 0",
                     mem_req, mem_addr, if_done, d_done, bus_err);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (mem_req !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: mem_req=%b if_done=%b d_done=%b, expected 0", mem_req, if_done, d_done);
        end
    endtask

    task automatic test_fetch();
        ack_delay = 0;
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h100;
        exp_q.push_back(exp_t'{is_d: 1'b0, data: 32'h8C22_0004, err: 1'b0});
        @(negedge clock);
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            miscompares++;
            $display("[TB] FAIL fetch_issue: mem_req=%b mem_we=%b mem_addr=%h, expected 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        @(negedge clock);
        vectors++;
        if (if_done !== 1'b1 || d_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fetch_done_timing: if_done=%b d_done=%b, expected 1 0", if_done, d_done);
        end
        if_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_store();
        ack_delay = 2;
        @(negedge clock);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'hDEAD_BEEF;
        exp_q.push_back(exp_t'{is_d: 1'b1, data: 32'h0, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 ||
                mem_wdata !== 32'hDEAD_BEEF || d_done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL store_hold cycle %0d: mem_req=%b mem_we=%b mem_addr=%h mem_wdata=%h d_done=%b, expected 1 1 00000010 deadbeef 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, d_done);
            end
        end
        @(negedge clock);
        vectors++;
        if (d_done !== 1'b1 || if_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_done: d_done=%b if_done=%b, expected 1 0", d_done, if_done);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        vectors++;
        if (!store_model.exists(32'h10) || store_model[32'h10] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL store_write: memory word at 0x10 not written with deadbeef");
        end
        @(negedge clock);
    endtask

    task automatic test_late_fetch();
        ack_delay = 0;
        @(negedge clock);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        exp_q.push_back(exp_t'{is_d: 1'b1, data: init_word(32'h300), err: 1'b0});
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h204;
        exp_q.push_back(exp_t'{is_d: 1'b0, data: init_word(32'h204), err: 1'b0});
        @(negedge clock);
        vectors++;
        if (d_done !== 1'b1 || if_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_fetch_load_first: d_done=%b if_done=%b, expected 1 0", d_done, if_done);
        end
        d_req = 1'b0;
        @(negedge clock);
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL late_fetch_idle: mem_req=%b, expected 0", mem_req);
        end
        @(negedge clock);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin
            miscompares++;
            $display("[TB] FAIL late_fetch_issue: mem_req=%b mem_addr=%h, expected 1 00000204", mem_req, mem_addr);
        end
        @(negedge clock);
        vectors++;
        if (if_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL late_fetch_done: if_done=%b, expected 1", if_done);
        end
        if_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int t;
        int last;
        int count;
        ack_delay = 0;
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h308;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4)
                exp_q.push_back(exp_t'{is_d: 1'b0, data: init_word(32'h200), err: 1'b0});
            else
                exp_q.push_back(exp_t'{is_d: 1'b1, data: init_word(32'h308), err: 1'b0});
        end
        t     = 0;
        last  = -1;
        count = 0;
        while (count < 10 && t < 100) begin
            @(negedge clock);
            t++;
            if (if_done || d_done) begin
                count++;
                if (last >= 0) begin
                    vectors++;
                    if (t - last != 3) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_spacing: got %0d cycles between dones, expected 3", t - last);
                    end
                end
                last = t;
                if (count == 10) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        vectors++;
        if (count != 10) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d completions, expected 10", count);
        end
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        ack_delay = -1;
        @(negedge clock);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        exp_q.push_back(exp_t'{is_d: 1'b1, data: 32'h0, err: 1'b1});
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (d_done || if_done) seen = 1'b1;
            else if (mem_req) n++;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL timeout_done: no done within 40 cycles, expected done+err");
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("[TB] FAIL timeout_req_cycles: mem_req high %0d cycles, expected 8", n);
        end
        vectors++;
        if (bus_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bus_err_set: bus_err=%b, expected 1", bus_err);
        end
        d_req = 1'b0;
        @(negedge clock);
        force_ack = 1'b1;
        @(negedge clock);
        force_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (if_done || d_done || mem_req) seen = 1'b1;
        end
        vectors++;
        if (seen || bus_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL late_ack_ignored: activity=%b bus_err=%b, expected 0 1", seen, bus_err);
        end
        ack_delay = 1;
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h208;
        exp_q.push_back(exp_t'{is_d: 1'b0, data: init_word(32'h208), err: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (if_done || d_done) seen = 1'b1;
        end
        if_req = 1'b0;
        vectors++;
        if (!seen || bus_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL after_timeout_fetch: done=%b bus_err=%b, expected 1 1", seen, bus_err);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit seen;
        ack_delay = -1;
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h20C;
        repeat (2) @(negedge clock);
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_pre: mem_req=%b, expected 1", mem_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || bus_err !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_async: mem_req=%b bus_err=%b if_done=%b d_done=%b err=%b, expected all 0",
                     mem_req, bus_err, if_done, d_done, err);
        end
        if_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (if_done || d_done || mem_req) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_no_done: activity after release=%b, expected 0", seen);
        end
        ack_delay = 0;
        @(negedge clock);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h44;
        exp_q.push_back(exp_t'{is_d: 1'b1, data: init_word(32'h44), err: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (if_done || d_done) seen = 1'b1;
        end
        d_req = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_fresh: no done for fresh load, expected one");
        end
        @(negedge clock);
    endtask

    // Test sequence with a completion monitor popping the expected-result queue.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        if_req      = 1'b0;
        if_addr     = '0;
        d_req       = 1'b0;
        d_we        = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;
        force_ack   = 1'b0;
        ack_delay   = 0;

        fork
            begin : monitor
                exp_t        e;
                logic [31:0] got;
                forever begin
                    @(negedge clock);
                    if (reset_n && (if_done || d_done)) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("[TB] FAIL unexpected_done: if_done=%b d_done=%b with nothing expected", if_done, d_done);
                        end else begin
                            e   = exp_q.pop_front();
                            got = d_done ? d_rdata : if_rdata;
                            if ({if_done, d_done} !== {~e.is_d, e.is_d}) begin
                                miscompares++;
                                $display("[TB] FAIL done_owner: if_done=%b d_done=%b, expected %b %b", if_done, d_done, ~e.is_d, e.is_d);
                            end
                            vectors++;
                            if (got !== e.data) begin
                                miscompares++;
                                $display("[TB] FAIL done_rdata: got %h, expected %h", got, e.data);
                            end
                            vectors++;
                            if (err !== e.err) begin
                                miscompares++;
                                $display("[TB] FAIL done_err: got %b, expected %b", err, e.err);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_fetch();
        test_store();
        test_late_fetch();
        test_back_to_back();
        test_timeout();
        test_reset_mid();

        repeat (2) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_done: %0d expected completions never seen", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, word-addressed memory between the core's instruction-fetch requester and its load/store requester. Each requester uses a req/done handshake; the memory side is a request/acknowledge port with variable latency. Data accesses have priority, bounded by an anti-starvation streak limit that guarantees fetch progress. A per-transaction timeout flags a hung memory.

## Interface
- ADDR_W, 32, address width (word address; PC-style +1 increments)
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (≥1)
- TIMEOUT, 64, cycles in ISSUE without mem_ack before abort (≥2)

- clock  in  1  single clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_done  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetch data, valid when if_done=1
- d_req  in  1  load/store request, held until d_done
- d_we  in  1  1=store, 0=load; stable while d_req=1
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data, valid when d_done=1
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ack  in  1  memory accepted/completed; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  memory read data
- err  out  1  one-cycle pulse with the done of an aborted transaction
- bus_err  out  1  sticky timeout flag; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: sample requests. Neither → stay. Only one → grant it. Both → grant data unless streak = MAX_D_STREAK, then grant fetch. On grant: latch owner, address, we (fetch: we=0), wdata; → ISSUE.
- Streak counter: +1 on data grant while if_req=1; cleared on fetch grant or when if_req=0 in IDLE; saturates at MAX_D_STREAK.
- ISSUE: mem_req=1, mem_we/mem_addr/mem_wdata driven from latches. mem_ack=1 → capture mem_rdata (loads/fetches; stores capture 0), → RESP. Timeout counter reaches TIMEOUT → drop mem_req, rdata=0, set err for RESP, set bus_err, → RESP.
- RESP: pulse owner's done with captured rdata; err pulses if aborted; → IDLE. Non-owner done stays 0.
- mem_ack outside ISSUE is ignored (late ack after timeout is discarded).
- Requesters must deassert or update req for the cycle after done; a req still high in IDLE is a new transaction.
- Request inputs are not re-sampled during ISSUE/RESP; changes there are ignored.
- Reset (any time, including mid-transaction): FSM → IDLE, all outputs 0 (done, err, bus_err, mem_req, mem_we, mem_addr, mem_wdata, rdata), streak and timeout counters 0; in-flight transaction dropped with no done.

## Timing
- Request sampled in IDLE at cycle N → mem_req=1 in cycle N+1.
- mem_ack sampled at cycle M (M ≥ N+1) → done=1 in M+1 → IDLE in M+2; next mem_req earliest M+3.
- Zero-wait memory (ack in N+1): done in N+2; back-to-back throughput one transaction per 3 cycles.
- Timeout: mem_req high for exactly TIMEOUT cycles (N+1..N+TIMEOUT); done+err in N+TIMEOUT+1.
- Outputs are registered; no combinational path from requester or memory inputs to any output.

## Test plan
- Single fetch, ack 1 cycle after mem_req, mem_rdata=0x8C220004 → if_done at N+2 with if_rdata=0x8C220004, mem_we=0, d_done never.
- Store d_addr=0x10, d_wdata=0xDEADBEEF, ack after 3 cycles → mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF held 3 cycles, d_done with d_rdata=0.
- if_req and d_req both held high continuously, MAX_D_STREAK=4 → grant order D,D,D,D,F,D,D,D,D,F; no requester waits more than 5 grants.
- No ack, TIMEOUT=8 → mem_req high 8 cycles, d_done+err pulse, d_rdata=0, bus_err stays 1; later ack ignored; next request completes normally.
- reset_n low mid-ISSUE → mem_req, done, bus_err drop to 0 immediately (asynchronously); no done after release; fresh request served from IDLE.
- Load with ack on first ISSUE cycle while if_req rises during ISSUE → load completes first, fetch granted in following IDLE.
